// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage from NUM_REQ requesters.
// The output register refills in the same cycle it drains, so a held-ready sink sees one word per cycle.
module pipeline_rr_arbiter #(
   parameter int unsigned DW      = 8,
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IW     = $clog2(NUM_REQ)
) (
   input  logic                         clk_i,
   input  logic                         arst_ni,
   input  logic                         clear_i,
   input  logic [NUM_REQ-1:0][DW-1:0]   data_in_i,
   input  logic [NUM_REQ-1:0]           data_in_valid_i,
   output logic [NUM_REQ-1:0]           data_in_ready_o,
   output logic [DW-1:0]                data_out_o,
   output logic [IW-1:0]                data_out_id_o,
   output logic                         data_out_valid_o,
   input  logic                         data_out_ready_i
);

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   logic          full_q, full_d;
   logic [DW-1:0] data_q, data_d;
   logic [IW-1:0] id_q,   id_d;
   logic [IW-1:0] ptr_q,  ptr_d;

   logic          space;
   logic          hi_found, lo_found, grant_found, accept;
   logic [IW-1:0] hi_idx, lo_idx, grant_idx;

   assign space = ~full_q | data_out_ready_i;

   // Rotating priority as two fixed-priority scans: indices at/above ptr win over those below it.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (data_in_valid_i[i] && (IW'(i) >= ptr_q) && !hi_found) begin
            hi_found = 1'b1;
            hi_idx   = IW'(i);
         end
         if (data_in_valid_i[i] && (IW'(i) < ptr_q) && !lo_found) begin
            lo_found = 1'b1;
            lo_idx   = IW'(i);
         end
      end
      grant_found = hi_found | lo_found;
      grant_idx   = hi_found ? hi_idx : lo_idx;
   end

   // Ready is also masked by arst_ni so nothing is handshaken while reset is held.
   assign accept = grant_found & space & ~clear_i & arst_ni;

   always_comb begin
      data_in_ready_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         data_in_ready_o[i] = accept & (grant_idx == IW'(i));
      end
   end

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      id_d   = id_q;
      ptr_d  = ptr_q;
      if (clear_i) begin
         full_d = 1'b0;
         ptr_d  = '0;
      end else if (accept) begin
         full_d = 1'b1;
         data_d = data_in_i[grant_idx];
         id_d   = grant_idx;
         ptr_d  = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
      end else if (full_q && data_out_ready_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         full_q <= 1'b0;
         data_q <= '0;
         id_q   <= '0;
         ptr_q  <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         id_q   <= id_d;
         ptr_q  <= ptr_d;
      end
   end

   assign data_out_o       = data_q;
   assign data_out_id_o    = id_q;
   assign data_out_valid_o = full_q;

endmodule
